approx_adder_error_sweeper: RTL and testbench
=============================================

// Module: approx_adder_error_sweeper
// PURPOSE
// - Sequential evaluation harness that reads back the outputs of a combinational approximate adder netlist (circuit under test, CUT).
// - Sweeps every input vector into the CUT and samples its sum outputs.
// - Compares each sample against the exact sum and reports max absolute error, error counts and pass/fail against the error threshold (ET).
// - Sits beside each generated approximate netlist on-chip/FPGA to confirm the ET guarantee in hardware.
// PARAMETERS
// - W       2  operand width; CUT has 2*W inputs and W+1 outputs
// - ET      1  error threshold; pass requires every |err| <= ET
// - SETTLE  1  cycles (>=1) a vector is held before its sample is taken
// PORTS
// - clk           in   1        single clock; all state changes on rising edge
// - rst_n         in   1        asynchronous, active-low reset
// - start         in   1        begin a sweep; honoured only in IDLE
// - abort         in   1        synchronous cancel of a running sweep
// - cut_in        out  2*W      vector to CUT: [W-1:0]=operand A, [2W-1:W]=operand B (in0 = LSB)
// - cut_out       in   W+1      CUT sum outputs (out0 = LSB)
// - busy          out  1        sweep in progress
// - done          out  1        one-cycle pulse at sweep completion
// - pass          out  1        1 if no vector exceeded ET (valid from done onward)
// - max_err       out  W+1      largest |cut_out - (A+B)| seen
// - err_count     out  2*W+1    vectors with nonzero error
// - first_fail    out  2*W      index of first vector with |err| > ET
// - fail_valid    out  1        first_fail holds a captured index
// BEHAVIOUR
// - Reset (async): state IDLE; cut_in=0; busy=0, done=0, pass=0, max_err=0, err_count=0, first_fail=0, fail_valid=0.
// - FSM IDLE -> SETTLE -> COMPARE -> (SETTLE | DONE) -> IDLE.
//   - IDLE: on start, clear all stats, set pass=1, cut_in=0, busy=1, go to SETTLE.
//   - SETTLE: hold cut_in for SETTLE cycles (down-counter), then go to COMPARE.
//   - COMPARE: sample cut_out.
//     - exact = A+B computed at W+1 bits (no overflow).
//     - err = |cut_out - exact| at W+1 bits, unsigned magnitude.
//     - max_err = max(max_err, err); err_count += (err != 0).
//     - If err > ET: pass=0, and if !fail_valid, capture first_fail=cut_in and set fail_valid=1.
//     - If cut_in == all-ones, go to DONE; else cut_in+1 and go to SETTLE.
//   - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
// - Per-vector cost: SETTLE+1 cycles. Done pulse occurs 2^(2W)*(SETTLE+1)+1 cycles after start is accepted.
// - start while busy: ignored. start and abort together in IDLE: abort wins, start dropped.
// - abort while busy: next cycle IDLE, busy=0, no done pulse, stats frozen, pass forced 0.
// - Results hold until the next accepted start. cut_in holds its last value while IDLE.
// - rst_n low mid-sweep: immediate clear as at reset; no done pulse.
// CONFIGURATION
// - MEAN_ERROR_EN defined: adds output err_sum [3*W:0] = sum of err over all vectors.
//   - Cleared on start; accumulated in COMPARE; reset 0.
//   - Width cannot overflow.
// - MEAN_ERROR_EN undefined: port and accumulator absent; all other behaviour identical.
// TESTING (W=2, ET=1, SETTLE=1 unless noted)
// - Exact model (cut_out = A+B), start pulse -> done at cycle 33; pass=1, max_err=0, err_count=0, fail_valid=0.
// - cut_out = 0 constant -> pass=0, max_err=6, err_count=15, first_fail=4'd2, fail_valid=1; with MEAN_ERROR_EN, err_sum=48.
// - cut_out = (A+B) ^ 1 -> pass=1, max_err=1, err_count=16, fail_valid=0.
// - SETTLE=3, exact model -> done at cycle 65; cut_in steps every 4 cycles, 0..15 in order.
// - abort at cycle 10 -> busy=0 next cycle, no done; start at cycle 10 during sweep is ignored.
// - rst_n low at cycle 20 -> all outputs 0 asynchronously; fresh start after release -> normal 33-cycle sweep.

Source files
------------

// File: rtl/approx_adder_error_sweeper.sv
// approx_adder_error_sweeper: drives every 2*W-bit operand vector into an
// approximate adder (CUT). For each vector it samples the CUT sum after a
// settle delay, compares it with the exact sum, and accumulates error
// statistics (max |err|, nonzero-error count, first vector over ET, pass).
// Optional feature: define MEAN_ERROR_EN to add the err_sum output, which
// holds the sum of |err| over the whole sweep.
module approx_adder_error_sweeper #(
  parameter int W      = 2,
  parameter int ET     = 1,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [2*W-1:0]   cut_in,
  input  logic [W:0]       cut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [W:0]       max_err,
  output logic [2*W:0]     err_count,
  output logic [2*W-1:0]   first_fail,
  output logic             fail_valid
`ifdef MEAN_ERROR_EN
  , output logic [3*W:0]   err_sum
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam int             CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [W:0]     ET_V     = (W+1)'(ET);
  localparam logic [2*W-1:0] VEC_LAST = '1;

  // Unsigned magnitude of the difference of two (W+1)-bit sums.
  function automatic logic [W:0] abs_diff(input logic [W:0] x, input logic [W:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]     cut_in_q, cut_in_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [W:0]         max_err_q, max_err_d;
  logic [2*W:0]       err_count_q, err_count_d;
  logic [2*W-1:0]     first_fail_q, first_fail_d;
  logic               fail_valid_q, fail_valid_d;
  logic [W:0]         exact;
  logic [W:0]         err;
`ifdef MEAN_ERROR_EN
  logic [3*W:0]       err_sum_q, err_sum_d;
`endif

  // Exact reference sum and error magnitude for the vector currently applied.
  always_comb begin
    exact = {1'b0, cut_in_q[W-1:0]} + {1'b0, cut_in_q[2*W-1:W]};
    err   = abs_diff(cut_out, exact);
  end

  // Sweep sequencing and statistics update; abort drops to IDLE with pass forced low.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cut_in_d     = cut_in_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    max_err_d    = max_err_q;
    err_count_d  = err_count_q;
    first_fail_d = first_fail_q;
    fail_valid_d = fail_valid_q;
`ifdef MEAN_ERROR_EN
    err_sum_d    = err_sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d      = S_SETTLE;
          cnt_d        = CNT_LOAD;
          cut_in_d     = '0;
          busy_d       = 1'b1;
          pass_d       = 1'b1;
          max_err_d    = '0;
          err_count_d  = '0;
          first_fail_d = '0;
          fail_valid_d = 1'b0;
`ifdef MEAN_ERROR_EN
          err_sum_d    = '0;
`endif
        end
      end
      S_SETTLE: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = S_COMPARE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_COMPARE: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          pass_d  = 1'b0;
        end else begin
          if (err > max_err_q) max_err_d = err;
          if (err != '0) err_count_d = err_count_q + 1'b1;
`ifdef MEAN_ERROR_EN
          err_sum_d = err_sum_q + {{(2*W){1'b0}}, err};
`endif
          if (err > ET_V) begin
            pass_d = 1'b0;
            if (!fail_valid_q) begin
              first_fail_d = cut_in_q;
              fail_valid_d = 1'b1;
            end
          end
          if (cut_in_q == VEC_LAST) begin
            state_d = S_DONE;
          end else begin
            cut_in_d = cut_in_q + 1'b1;
            cnt_d    = CNT_LOAD;
            state_d  = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (abort) begin
          pass_d = 1'b0;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers; asynchronous reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cut_in_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      max_err_q    <= '0;
      err_count_q  <= '0;
      first_fail_q <= '0;
      fail_valid_q <= 1'b0;
`ifdef MEAN_ERROR_EN
      err_sum_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cut_in_q     <= cut_in_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      max_err_q    <= max_err_d;
      err_count_q  <= err_count_d;
      first_fail_q <= first_fail_d;
      fail_valid_q <= fail_valid_d;
`ifdef MEAN_ERROR_EN
      err_sum_q    <= err_sum_d;
`endif
    end
  end

  assign cut_in     = cut_in_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign max_err    = max_err_q;
  assign err_count  = err_count_q;
  assign first_fail = first_fail_q;
  assign fail_valid = fail_valid_q;
`ifdef MEAN_ERROR_EN
  assign err_sum    = err_sum_q;
`endif

endmodule

// File: tb/tb_approx_adder_error_sweeper.sv
// Bench for approx_adder_error_sweeper (W=2, ET=1). One instance uses
// SETTLE=1 with a selectable CUT model; a second uses SETTLE=3 with an
// exact CUT. Directed sweeps with hand-computed results.
module tb_approx_adder_error_sweeper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [3:0] cut_in;
  logic [2:0] cut_out;
  logic       busy, done, pass, fail_valid;
  logic [2:0] max_err;
  logic [4:0] err_count;
  logic [3:0] first_fail;

  logic       start3;
  logic [3:0] cut_in3;
  logic [2:0] cut_out3;
  logic       busy3, done3, pass3, fail_valid3;
  logic [2:0] max_err3;
  logic [4:0] err_count3;
  logic [3:0] first_fail3;

`ifdef MEAN_ERROR_EN
  logic [6:0] err_sum, err_sum3;
`endif

  int mode;   // 0 exact, 1 constant zero, 2 exact xor 1
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  approx_adder_error_sweeper #(.W(2), .ET(1), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cut_in(cut_in), .cut_out(cut_out), .busy(busy), .done(done),
    .pass(pass), .max_err(max_err), .err_count(err_count),
    .first_fail(first_fail), .fail_valid(fail_valid)
`ifdef MEAN_ERROR_EN
    , .err_sum(err_sum)
`endif
  );

  approx_adder_error_sweeper #(.W(2), .ET(1), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(1'b0),
    .cut_in(cut_in3), .cut_out(cut_out3), .busy(busy3), .done(done3),
    .pass(pass3), .max_err(max_err3), .err_count(err_count3),
    .first_fail(first_fail3), .fail_valid(fail_valid3)
`ifdef MEAN_ERROR_EN
    , .err_sum(err_sum3)
`endif
  );

  // CUT models
  always_comb begin
    logic [2:0] s;
    s = {1'b0, cut_in[1:0]} + {1'b0, cut_in[3:2]};
    case (mode)
      1:       cut_out = 3'd0;
      2:       cut_out = s ^ 3'd1;
      default: cut_out = s;
    endcase
  end

  always_comb cut_out3 = {1'b0, cut_in3[1:0]} + {1'b0, cut_in3[3:2]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, exp);
    end
  endtask

  // Accept a start on dut, then count cycles until done rises.
  task automatic run1(output int cyc);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    cyc = 0;
    while (!done && cyc < 300) begin
      @(posedge clk); #1; cyc++;
    end
    if (!done) chk("sweep_timeout", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("cut_in_last", 32'(cut_in), 32'd15);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int cyc;
    int seen;
    #2000000;
    $display("FAIL global_timeout: got=1 want=0");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int seen;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; start3 = 1'b0; mode = 0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_max_err", 32'(max_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_first_fail", 32'(first_fail), 32'd0);
    chk("rst_fail_valid", 32'(fail_valid), 32'd0);
    chk("rst_cut_in", 32'(cut_in), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // exact model
    mode = 0;
    run1(cyc);
    chk("exact_cycles", 32'(cyc), 32'd33);
    chk("exact_pass", 32'(pass), 32'd1);
    chk("exact_max_err", 32'(max_err), 32'd0);
    chk("exact_err_count", 32'(err_count), 32'd0);
    chk("exact_fail_valid", 32'(fail_valid), 32'd0);
`ifdef MEAN_ERROR_EN
    chk("exact_err_sum", 32'(err_sum), 32'd0);
`endif

    // constant-zero model
    mode = 1;
    run1(cyc);
    chk("zero_cycles", 32'(cyc), 32'd33);
    chk("zero_pass", 32'(pass), 32'd0);
    chk("zero_max_err", 32'(max_err), 32'd6);
    chk("zero_err_count", 32'(err_count), 32'd15);
    chk("zero_first_fail", 32'(first_fail), 32'd2);
    chk("zero_fail_valid", 32'(fail_valid), 32'd1);
`ifdef MEAN_ERROR_EN
    chk("zero_err_sum", 32'(err_sum), 32'd48);
`endif

    // LSB-flipped model: every vector off by exactly ET
    mode = 2;
    run1(cyc);
    chk("xor_pass", 32'(pass), 32'd1);
    chk("xor_max_err", 32'(max_err), 32'd1);
    chk("xor_err_count", 32'(err_count), 32'd16);
    chk("xor_fail_valid", 32'(fail_valid), 32'd0);
`ifdef MEAN_ERROR_EN
    chk("xor_err_sum", 32'(err_sum), 32'd16);
`endif

    // SETTLE=3 instance: cut_in steps every 4 cycles
    @(negedge clk); start3 = 1'b1;
    @(posedge clk); #1; start3 = 1'b0;
    cyc = 0;
    chk("s3_cut_in_step", 32'(cut_in3), 32'd0);
    while (!done3 && cyc < 300) begin
      @(posedge clk); #1; cyc++;
      if (cyc < 64) chk("s3_cut_in_step", 32'(cut_in3), 32'(cyc / 4));
    end
    chk("s3_cycles", 32'(cyc), 32'd65);
    chk("s3_pass", 32'(pass3), 32'd1);
    chk("s3_max_err", 32'(max_err3), 32'd0);

    // abort mid-sweep, with an ignored start along the way
    mode = 1;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("start_ignored_cut_in", 32'(cut_in), 32'd2);
    repeat (4) @(posedge clk);
    #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_pass", 32'(pass), 32'd0);
    chk("abort_err_count", 32'(err_count), 32'd3);
    chk("abort_max_err", 32'(max_err), 32'd3);
    chk("abort_first_fail", 32'(first_fail), 32'd2);
    chk("abort_cut_in_hold", 32'(cut_in), 32'd4);
`ifdef MEAN_ERROR_EN
    chk("abort_err_sum", 32'(err_sum), 32'd6);
`endif
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    // start and abort together in IDLE: abort wins
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd0);
    chk("start_abort_err_count", 32'(err_count), 32'd3);

    // asynchronous reset mid-sweep
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (19) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cut_in", 32'(cut_in), 32'd0);
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
    chk("mid_rst_max_err", 32'(max_err), 32'd0);
    chk("mid_rst_fail_valid", 32'(fail_valid), 32'd0);
    chk("mid_rst_first_fail", 32'(first_fail), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mode = 0;
    run1(cyc);
    chk("post_rst_cycles", 32'(cyc), 32'd33);
    chk("post_rst_pass", 32'(pass), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
